// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel bus timer: register offsets,
// CTRL bit positions and the per-channel control struct.
package multi_timer_pkg;

  // Per-channel register offsets within an 8-byte channel slot
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_RLD_LO = 3'd1;
  localparam logic [2:0] OFF_RLD_HI = 3'd2;
  localparam logic [2:0] OFF_CNT_LO = 3'd3;
  localparam logic [2:0] OFF_CNT_HI = 3'd4;

  // Global register offsets within the 256-byte window
  localparam logic [7:0] OFF_PEND = 8'hf0;
  localparam logic [7:0] OFF_PRE  = 8'hf1;
  localparam logic [7:0] OFF_TIME = 8'hf2;

  // CTRL bit indices
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_START    = 3;

  // Stored CTRL bits; start is a strobe and is never stored
  typedef struct packed {
    logic ie;
    logic periodic;
    logic en;
  } ch_ctrl_t;

  // CTRL readback image (start always reads 0)
  function automatic logic [7:0] ctrl_rd(input ch_ctrl_t c);
    return {5'b0, c.ie, c.periodic, c.en};
  endfunction

endpackage

// File: rtl/bus_t.sv
// Shared 8-bit slave bus with a combined interrupt line.
interface bus_t;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wreq;
  logic        rreq;
  logic [7:0]  rdata;
  logic        ack;
  logic        irq;

  modport sub (
    input  addr, wdata, wreq, rreq,
    output rdata, ack, irq
  );

  modport master (
    output addr, wdata, wreq, rreq,
    input  rdata, ack, irq
  );
endinterface

// File: rtl/multi_timer_chan.sv
// One timer channel: control bits, reload register, down-counter,
// count high-byte shadow and the pending-set strobe for the top level.
module timer_chan
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ctrl_we,
  input  logic             rld_lo_we,
  input  logic             rld_hi_we,
  input  logic             cnt_latch,
  input  logic [7:0]       wdata,
  output ch_ctrl_t         ctrl,
  output logic [WIDTH-1:0] rld,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-9:0] shadow,
  output logic             pend_set
);

  localparam int               HIW = WIDTH - 8;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic start_wr;
  logic expire;

  assign start_wr = ctrl_we & wdata[CTRL_START];
  // A start in the same clock as terminal count restarts the channel and
  // swallows that expiry.
  assign expire   = tick & ctrl.en & (cnt == ONE);
  assign pend_set = expire & ~start_wr;

  // Control, reload, counter and shadow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= '0;
      rld    <= '0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      if (ctrl_we) begin
        ctrl.en       <= wdata[CTRL_EN];
        ctrl.periodic <= wdata[CTRL_PERIODIC];
        ctrl.ie       <= wdata[CTRL_IE];
      end
      if (rld_lo_we) rld[7:0] <= wdata;
      if (rld_hi_we) rld[WIDTH-1:8] <= wdata[HIW-1:0];

      if (start_wr) begin
        cnt <= rld;
      end else if (tick && ctrl.en) begin
        if (cnt > ONE) begin
          cnt <= cnt - ONE;
        end else if (cnt == ONE) begin
          if (ctrl.periodic) begin
            cnt <= rld;
          end else begin
            cnt <= '0;
            // A CTRL write in this clock owns the enable bit
            if (!ctrl_we) ctrl.en <= 1'b0;
          end
        end
      end

      if (cnt_latch) shadow <= cnt[WIDTH-1:8];
    end
  end

endmodule

// File: rtl/multi_timer.sv
// NCH-channel bus timer: address decode, bus handshake, shared prescaler,
// pending-interrupt register, free-running TIME counter and combined irq.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int          NCH   = 4,
  parameter int          WIDTH = 16,
  parameter logic [15:0] BASE  = 16'hfb00
) (
  input logic clk,
  input logic rst,
  bus_t.sub   bus
);

  localparam int HIW = WIDTH - 8;

  logic           ack_q;
  logic [7:0]     rdata_q;
  logic           irq_q;
  logic [7:0]     pre;
  logic [7:0]     pcnt;
  logic [7:0]     time_q;
  logic [NCH-1:0] pend;
  logic           tick;

  logic           in_win;
  logic           accept;
  logic           wr;
  logic           rd;
  logic [7:0]     off;
  logic [2:0]     sub_off;
  logic [2:0]     ch_sel;
  logic           ch_hit;
  logic [7:0]     rd_val;
  logic [NCH-1:0] w1c;

  ch_ctrl_t         ctrl_v   [NCH];
  logic [WIDTH-1:0] rld_v    [NCH];
  logic [WIDTH-1:0] cnt_v    [NCH];
  logic [HIW-1:0]   shadow_v [NCH];
  logic [NCH-1:0]   pend_set;
  logic [NCH-1:0]   ie_vec;

  assign off     = bus.addr[7:0];
  assign in_win  = (bus.addr[15:8] == BASE[15:8]);
  // The ack cycle never accepts, so a held request is taken once per ack
  assign accept  = in_win & ~ack_q & (bus.wreq | bus.rreq);
  assign wr      = accept & bus.wreq;
  assign rd      = accept & bus.rreq;
  assign sub_off = off[2:0];
  assign ch_sel  = off[5:3];
  assign ch_hit  = (off[7:6] == 2'b00) && (int'(ch_sel) < NCH);
  assign tick    = (pcnt == pre);
  assign w1c     = (wr && off == OFF_PEND) ? bus.wdata[NCH-1:0] : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic sel;
    assign sel = ch_hit && (ch_sel == 3'(g));

    timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .ctrl_we   (wr & sel & (sub_off == OFF_CTRL)),
      .rld_lo_we (wr & sel & (sub_off == OFF_RLD_LO)),
      .rld_hi_we (wr & sel & (sub_off == OFF_RLD_HI)),
      .cnt_latch (rd & sel & (sub_off == OFF_CNT_LO)),
      .wdata     (bus.wdata),
      .ctrl      (ctrl_v[g]),
      .rld       (rld_v[g]),
      .cnt       (cnt_v[g]),
      .shadow    (shadow_v[g]),
      .pend_set  (pend_set[g])
    );

    assign ie_vec[g] = ctrl_v[g].ie;
  end

  // Read data mux; evaluated on pre-write state so a combined read/write
  // returns the old register contents
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_PEND: rd_val = 8'(pend);
      OFF_PRE:  rd_val = pre;
      OFF_TIME: rd_val = time_q;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_hit && ch_sel == 3'(i)) begin
            case (sub_off)
              OFF_CTRL:   rd_val = ctrl_rd(ctrl_v[i]);
              OFF_RLD_LO: rd_val = rld_v[i][7:0];
              OFF_RLD_HI: rd_val = 8'(rld_v[i][WIDTH-1:8]);
              OFF_CNT_LO: rd_val = cnt_v[i][7:0];
              OFF_CNT_HI: rd_val = 8'(shadow_v[i]);
              default:    rd_val = '0;
            endcase
          end
        end
      end
    endcase
  end

  // Bus response: one-cycle ack with data captured at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= accept;
      if (accept) rdata_q <= rd_val;
    end
  end

  // Prescaler; a PRE write restarts the tick phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre  <= '0;
      pcnt <= '0;
    end else if (wr && off == OFF_PRE) begin
      pre  <= bus.wdata;
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // Pending bits: write-1-to-clear, with a same-clock set taking priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~w1c) | pend_set;
    end
  end

  // Free-running clock counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q <= '0;
    end else begin
      time_q <= time_q + 8'd1;
    end
  end

  // Combined interrupt, registered from the current pending/enable state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(pend & ie_vec);
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule
